axa_undo_unit: RTL and testbench

AXA_UNDO_UNIT -- requirements
Module: axa_undo_unit

---
 rtl/axa_pkg.sv | 19 +
 rtl/axa_undo_unit_if.sv | 37 +++
 rtl/axa_undo_ram.sv | 35 +++
 rtl/axa_undo_unit.sv | 147 ++++++++++++++
 tb/tb_axa_undo_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/axa_pkg.sv
// Shared widths, undo-entry layout and FSM state encoding for the AXA undo unit.
package axa_pkg;

  localparam int unsigned AXA_WORD_W = 16;
  localparam int unsigned AXA_REG_W  = 4;
  localparam int unsigned AXA_UPTR_W = 4;

  typedef struct packed {
    logic [AXA_REG_W-1:0]  regn;
    logic [AXA_WORD_W-1:0] val;
  } undo_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StRewind,
    StDone
  } undo_state_e;

endpackage

// File: rtl/axa_undo_unit_if.sv
// Push / peek / rewind / restore signal bundle between the pipeline and the undo unit.
interface axa_undo_unit_if
  import axa_pkg::*;
#(
  parameter int unsigned UPTR_W = AXA_UPTR_W
);

  logic                  push_valid;
  logic                  push_ready;
  logic [AXA_REG_W-1:0]  push_reg;
  logic [AXA_WORD_W-1:0] push_val;
  logic [UPTR_W-1:0]     peek_idx;
  logic [AXA_WORD_W-1:0] peek_data;
  logic                  peek_valid;
  logic                  rewind_start;
  logic [UPTR_W:0]       rewind_count;
  logic                  restore_we;
  logic [AXA_REG_W-1:0]  restore_reg;
  logic [AXA_WORD_W-1:0] restore_val;
  logic                  rewind_busy;
  logic                  rewind_done;
  logic                  underflow;
  logic                  overflow_drop;

  modport master (
    output push_valid, push_reg, push_val, peek_idx, rewind_start, rewind_count,
    input  push_ready, peek_data, peek_valid, restore_we, restore_reg, restore_val,
           rewind_busy, rewind_done, underflow, overflow_drop
  );

  modport slave (
    input  push_valid, push_reg, push_val, peek_idx, rewind_start, rewind_count,
    output push_ready, peek_data, peek_valid, restore_we, restore_reg, restore_val,
           rewind_busy, rewind_done, underflow, overflow_drop
  );

endinterface

// File: rtl/axa_undo_ram.sv
// Undo storage: one synchronous write port, combinational pop read and (with
// AXA_UNDO_PEEK_EN) a combinational peek read.
module axa_undo_ram
  import axa_pkg::*;
#(
  parameter int unsigned UPTR_W = AXA_UPTR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [UPTR_W-1:0] waddr_i,
  input  undo_entry_t       wdata_i,
  input  logic [UPTR_W-1:0] pop_addr_i,
  output undo_entry_t       pop_data_o
`ifdef AXA_UNDO_PEEK_EN
  ,
  input  logic [UPTR_W-1:0] peek_addr_i,
  output undo_entry_t       peek_data_o
`endif
);

  undo_entry_t mem_q [2**UPTR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign pop_data_o = mem_q[pop_addr_i];

`ifdef AXA_UNDO_PEEK_EN
  assign peek_data_o = mem_q[peek_addr_i];
`endif

endmodule

// File: rtl/axa_undo_unit.sv
// Circular undo stack with a reverse-execution sequencer that replays saved
// register values. Optional peek port enabled by AXA_UNDO_PEEK_EN.
module axa_undo_unit
  import axa_pkg::*;
#(
  parameter int unsigned UPTR_W = AXA_UPTR_W
) (
  input  logic           clk_i,
  input  logic           reset_i,
  axa_undo_unit_if.slave bus
);

  localparam logic [UPTR_W:0] OccFull = (UPTR_W + 1)'(2 ** UPTR_W);

  undo_state_e       state_q, state_d;
  logic [UPTR_W-1:0] sp_q, sp_d;
  logic [UPTR_W:0]   occ_q, occ_d;
  logic [UPTR_W:0]   rem_q, rem_d;
  logic              restore_we_q, restore_we_d;
  undo_entry_t       restore_q, restore_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              underflow_q, underflow_d;

  logic              ram_we;
  undo_entry_t       ram_wdata;
  undo_entry_t       pop_entry;
  logic [UPTR_W-1:0] pop_addr;

  assign ram_wdata = '{regn: bus.push_reg, val: bus.push_val};
  assign pop_addr  = sp_q - 1'b1;

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    occ_d        = occ_q;
    rem_d        = rem_q;
    restore_we_d = 1'b0;
    restore_d    = restore_q;
    done_d       = 1'b0;
    ovf_d        = 1'b0;
    underflow_d  = underflow_q;
    ram_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.push_valid) begin
          ram_we = 1'b1;
          sp_d   = sp_q + 1'b1;
          if (occ_q == OccFull) begin
            ovf_d = 1'b1;
          end else begin
            occ_d = occ_q + 1'b1;
          end
        end
        // The push lands this edge, so the first pop sees it at sp-1.
        if (bus.rewind_start && (bus.rewind_count != '0)) begin
          rem_d   = bus.rewind_count;
          state_d = StRewind;
        end
      end
      StRewind: begin
        if (occ_q == '0) begin
          underflow_d = 1'b1;
          state_d     = StDone;
        end else begin
          restore_we_d = 1'b1;
          restore_d    = pop_entry;
          sp_d         = sp_q - 1'b1;
          occ_d        = occ_q - 1'b1;
          rem_d        = rem_q - 1'b1;
          if (rem_q == (UPTR_W + 1)'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      sp_q         <= '0;
      occ_q        <= '0;
      rem_q        <= '0;
      restore_we_q <= 1'b0;
      restore_q    <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      occ_q        <= occ_d;
      rem_q        <= rem_d;
      restore_we_q <= restore_we_d;
      restore_q    <= restore_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.push_ready    = (state_q == StIdle);
  assign bus.rewind_busy   = (state_q == StRewind) || (state_q == StDone);
  assign bus.rewind_done   = done_q;
  assign bus.restore_we    = restore_we_q;
  assign bus.restore_reg   = restore_q.regn;
  assign bus.restore_val   = restore_q.val;
  assign bus.underflow     = underflow_q;
  assign bus.overflow_drop = ovf_q;

`ifdef AXA_UNDO_PEEK_EN
  undo_entry_t       peek_entry;
  logic [UPTR_W-1:0] peek_addr;

  // Index is counted from the top of stack and wraps like the pipeline's read.
  assign peek_addr      = sp_q - bus.peek_idx - 1'b1;
  assign bus.peek_data  = peek_entry.val;
  assign bus.peek_valid = ({1'b0, bus.peek_idx} < occ_q);
`else
  assign bus.peek_data  = '0;
  assign bus.peek_valid = 1'b0;
`endif

  axa_undo_ram #(
    .UPTR_W(UPTR_W)
  ) u_ram (
    .clk_i      (clk_i),
    .we_i       (ram_we),
    .waddr_i    (sp_q),
    .wdata_i    (ram_wdata),
    .pop_addr_i (pop_addr),
    .pop_data_o (pop_entry)
`ifdef AXA_UNDO_PEEK_EN
    ,
    .peek_addr_i(peek_addr),
    .peek_data_o(peek_entry)
`endif
  );

endmodule

// File: tb/tb_axa_undo_unit.sv
// Directed self-checking bench for axa_undo_unit: push/rewind ordering, overflow,
// underflow, reset abort, push/rewind collision and peek.
module tb_axa_undo_unit;
  import axa_pkg::*;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  axa_undo_unit_if #(.UPTR_W(4)) bus ();

  axa_undo_unit #(
    .UPTR_W(4)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [19:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic push(input logic [3:0] r, input logic [15:0] v);
    bus.push_valid = 1'b1;
    bus.push_reg   = r;
    bus.push_val   = v;
    @(negedge clk_i);
    bus.push_valid = 1'b0;
  endtask

  // Cycle 0 is the cycle rewind_start is sampled; writes expected in exp_q order.
  task automatic run_rewind(input logic [4:0] cnt, input logic do_push, input logic [19:0] pe,
                            input logic busy_push, input int exp_done);
    int nw;
    int done_cyc;
    nw                = 0;
    done_cyc          = -1;
    bus.rewind_start  = 1'b1;
    bus.rewind_count  = cnt;
    bus.push_valid    = do_push;
    {bus.push_reg, bus.push_val} = pe;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk_i);
      bus.rewind_start = 1'b0;
      if (busy_push && bus.rewind_busy) begin
        bus.push_valid = 1'b1;
        bus.push_val   = 16'hBBBB;
        check_eq("busy_push_ready", {31'd0, bus.push_ready}, 32'd0);
      end else begin
        bus.push_valid = 1'b0;
      end
      if (bus.restore_we) begin
        if (nw < exp_q.size()) begin
          check_eq("rw_data", {12'd0, bus.restore_reg, bus.restore_val}, {12'd0, exp_q[nw]});
          check_eq("rw_cycle", cyc, nw + 2);
        end
        nw++;
      end
      if (bus.rewind_done) done_cyc = cyc;
    end
    bus.push_valid = 1'b0;
    check_eq("rw_count", nw, exp_q.size());
    check_eq("done_cycle", done_cyc, exp_done);
  endtask

  initial begin
    int nwe;
    int ndone;
    int novf;
    bus.push_valid   = 1'b0;
    bus.push_reg     = '0;
    bus.push_val     = '0;
    bus.peek_idx     = '0;
    bus.rewind_start = 1'b0;
    bus.rewind_count = '0;

    do_reset();
    check_eq("rst_ready", {31'd0, bus.push_ready}, 32'd1);
    check_eq("rst_we", {31'd0, bus.restore_we}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.rewind_busy}, 32'd0);
    check_eq("rst_uflow", {31'd0, bus.underflow}, 32'd0);
    check_eq("rst_ovf", {31'd0, bus.overflow_drop}, 32'd0);
    check_eq("rst_peek_valid", {31'd0, bus.peek_valid}, 32'd0);

    // rewind_count == 0 is ignored
    bus.rewind_start = 1'b1;
    bus.rewind_count = 5'd0;
    @(negedge clk_i);
    bus.rewind_start = 1'b0;
    check_eq("cnt0_busy", {31'd0, bus.rewind_busy}, 32'd0);

    // Three pushes unwound in reverse order, then the stack is empty
    push(4'd1, 16'h1111);
    push(4'd2, 16'h2222);
    push(4'd3, 16'h3333);
    exp_q = '{{4'd3, 16'h3333}, {4'd2, 16'h2222}, {4'd1, 16'h1111}};
    run_rewind(5'd3, 1'b0, 20'd0, 1'b0, 5);
    check_eq("r3_uflow", {31'd0, bus.underflow}, 32'd0);
    exp_q = {};
    run_rewind(5'd1, 1'b0, 20'd0, 1'b0, 3);
    check_eq("r3_empty_uflow", {31'd0, bus.underflow}, 32'd1);

    // Underflow partway through a rewind
    do_reset();
    push(4'd5, 16'h0055);
    push(4'd6, 16'h0066);
    exp_q = '{{4'd6, 16'h0066}, {4'd5, 16'h0055}};
    run_rewind(5'd4, 1'b0, 20'd0, 1'b0, 5);
    check_eq("uf_sticky", {31'd0, bus.underflow}, 32'd1);

    // Overflow: 17 pushes, oldest dropped
    do_reset();
    novf = 0;
    for (int i = 0; i < 17; i++) begin
      push(4'(i), 16'(i));
      if (bus.overflow_drop) novf++;
      if (i == 16) check_eq("ovf_on_17th", {31'd0, bus.overflow_drop}, 32'd1);
    end
    check_eq("ovf_pulses", novf, 1);
    bus.peek_idx = 4'd15;
    #1;
`ifdef AXA_UNDO_PEEK_EN
    check_eq("peek15_data", {16'd0, bus.peek_data}, 32'd1);
    check_eq("peek15_valid", {31'd0, bus.peek_valid}, 32'd1);
`else
    check_eq("peek15_data", {16'd0, bus.peek_data}, 32'd0);
    check_eq("peek15_valid", {31'd0, bus.peek_valid}, 32'd0);
`endif
    bus.peek_idx = 4'd0;
    exp_q = {};
    for (int i = 16; i >= 1; i--) exp_q.push_back({4'(i), 16'(i)});
    run_rewind(5'd16, 1'b0, 20'd0, 1'b0, 18);
    check_eq("ovf_uflow", {31'd0, bus.underflow}, 32'd0);

    // Reset in the cycle after the first restore write aborts the rewind
    do_reset();
    for (int i = 1; i <= 5; i++) push(4'(i), 16'(16'h0100 + i));
    bus.rewind_start = 1'b1;
    bus.rewind_count = 5'd5;
    @(negedge clk_i);
    bus.rewind_start = 1'b0;
    @(negedge clk_i);
    check_eq("abort_first_we", {31'd0, bus.restore_we}, 32'd1);
    check_eq("abort_first_val", {16'd0, bus.restore_val}, 32'h0105);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    nwe   = 0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.restore_we) nwe++;
      if (bus.rewind_done) ndone++;
      @(negedge clk_i);
    end
    check_eq("abort_no_we", nwe, 0);
    check_eq("abort_no_done", ndone, 0);
    check_eq("abort_ready", {31'd0, bus.push_ready}, 32'd1);
    exp_q = {};
    run_rewind(5'd1, 1'b0, 20'd0, 1'b0, 3);
    check_eq("abort_occ0", {31'd0, bus.underflow}, 32'd1);

    // Push and rewind in the same cycle; pushes while busy are dropped
    do_reset();
    exp_q = '{{4'd4, 16'hAAAA}};
    run_rewind(5'd1, 1'b1, {4'd4, 16'hAAAA}, 1'b1, 3);
    check_eq("coll_uflow", {31'd0, bus.underflow}, 32'd0);
    exp_q = {};
    run_rewind(5'd2, 1'b0, 20'd0, 1'b0, 3);
    check_eq("coll_occ0", {31'd0, bus.underflow}, 32'd1);

    // Peek with three entries
    do_reset();
    push(4'd1, 16'd5);
    push(4'd2, 16'd6);
    push(4'd3, 16'd7);
    bus.peek_idx = 4'd0;
    #1;
`ifdef AXA_UNDO_PEEK_EN
    check_eq("peek0_data", {16'd0, bus.peek_data}, 32'd7);
    check_eq("peek0_valid", {31'd0, bus.peek_valid}, 32'd1);
`else
    check_eq("peek0_data", {16'd0, bus.peek_data}, 32'd0);
    check_eq("peek0_valid", {31'd0, bus.peek_valid}, 32'd0);
`endif
    bus.peek_idx = 4'd2;
    #1;
`ifdef AXA_UNDO_PEEK_EN
    check_eq("peek2_data", {16'd0, bus.peek_data}, 32'd5);
    check_eq("peek2_valid", {31'd0, bus.peek_valid}, 32'd1);
`else
    check_eq("peek2_data", {16'd0, bus.peek_data}, 32'd0);
    check_eq("peek2_valid", {31'd0, bus.peek_valid}, 32'd0);
`endif
    bus.peek_idx = 4'd3;
    #1;
    check_eq("peek3_valid", {31'd0, bus.peek_valid}, 32'd0);
`ifndef AXA_UNDO_PEEK_EN
    check_eq("peek3_data", {16'd0, bus.peek_data}, 32'd0);
`endif
    check_eq("idle_we", {31'd0, bus.restore_we}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
